// File: rtl/dma_fifo_writer.sv
// Streams length words from a source RAM into a FIFO; first write 2 cycles after start, one word/cycle after that.
// fifo_full stalls writes immediately and reads once the 2-entry skid buffer would overflow.
module dma_fifo_writer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W:0]   length,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              fifo_full,
  output logic              fifo_wr_enable,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W-1:0] rd_ptr;

  logic              rd_vld;
  logic [DATA_W-1:0] slot [2];
  logic              head;
  logic              tail;
  logic [1:0]        cnt;
  logic [1:0]        occ;
  logic              room;

  // Occupancy the buffer reaches after this edge; a new read lands one edge later.
  always_comb begin
    fifo_wr_enable = (cnt != 2'd0) && !fifo_full;
    fifo_wr_data   = slot[head];
    occ            = cnt + {1'b0, rd_vld} - {1'b0, fifo_wr_enable};
    room           = (occ < 2'd2);
    mem_rd_en      = (state == RUN) && (rd_cnt < len_q) && room;
    mem_addr       = rd_ptr;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      len_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      rd_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= length;
            rd_ptr <= src_addr;
            rd_cnt <= '0;
            wr_cnt <= '0;
            if (length != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mem_rd_en) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            rd_cnt <= rd_cnt + (ADDR_W+1)'(1);
          end
          if (fifo_wr_enable) begin
            wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
            if (wr_cnt == len_q - (ADDR_W+1)'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // RAM data is valid the cycle after mem_rd_en and is captured at the end of that cycle.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rd_vld  <= 1'b0;
      head    <= 1'b0;
      tail    <= 1'b0;
      cnt     <= 2'd0;
      slot[0] <= '0;
      slot[1] <= '0;
    end else begin
      rd_vld <= mem_rd_en;
      if (rd_vld) begin
        slot[tail] <= mem_rd_data;
        tail       <= ~tail;
      end
      if (fifo_wr_enable) begin
        head <= ~head;
      end
      cnt <= cnt + {1'b0, rd_vld} - {1'b0, fifo_wr_enable};
    end
  end

endmodule

// File: tb/tb_dma_fifo_writer.sv
// Scoreboard bench for dma_fifo_writer: expected addresses/words queued at start, popped as the DUT reads/writes.
module tb_dma_fifo_writer;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW:0]   length;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          fifo_full;
  logic          fifo_wr_enable;
  logic [DW-1:0] fifo_wr_data;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  int ncyc = 0;
  int busy_cnt, done_cnt, done_idx, rd_total, wr_total, first_rd, first_wr, last_wr;
  int cnt_m = 0;
  int v1_m  = 0;

  dma_fifo_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .start(start), .src_addr(src_addr), .length(length),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .fifo_full(fifo_full), .fifo_wr_enable(fifo_wr_enable), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .done(done)
  );

  always #5 wclk = ~wclk;

  // Synchronous-read source RAM: RAM[i] = i + 0x100.
  always @(posedge wclk) begin
    if (mem_rd_en) mem_rd_data <= 32'h100 + {{(DW-AW){1'b0}}, mem_addr};
  end

  always @(negedge wclk) begin
    if (!wrst_n) begin
      cnt_m = 0;
      v1_m  = 0;
    end else begin
      checks++;
      if (fifo_wr_enable !== ((cnt_m != 0) && !fifo_full)) begin
        failures++;
        $display("FAIL wr_enable_rule cyc=%0d got=%b want=%b (buffered=%0d full=%b)",
                 ncyc, fifo_wr_enable, (cnt_m != 0) && !fifo_full, cnt_m, fifo_full);
      end
      if (mem_rd_en) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_read cyc=%0d addr=%0d", ncyc, mem_addr);
        end else begin
          logic [AW-1:0] ea;
          ea = exp_addr_q.pop_front();
          if (mem_addr !== ea) begin
            failures++;
            $display("FAIL read_addr cyc=%0d got=%0d want=%0d", ncyc, mem_addr, ea);
          end
        end
        checks++;
        if (cnt_m == 2 && !fifo_wr_enable) begin
          failures++;
          $display("FAIL read_when_buffer_full cyc=%0d got rd_en=1 want rd_en=0", ncyc);
        end
        if (rd_total == 0) first_rd = ncyc;
        rd_total++;
      end
      if (fifo_wr_enable) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d data=%h", ncyc, fifo_wr_data);
        end else begin
          logic [DW-1:0] ed;
          ed = exp_data_q.pop_front();
          if (fifo_wr_data !== ed) begin
            failures++;
            $display("FAIL write_data cyc=%0d got=%h want=%h", ncyc, fifo_wr_data, ed);
          end
        end
        if (wr_total == 0) first_wr = ncyc;
        last_wr = ncyc;
        wr_total++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_idx = ncyc;
      end
      cnt_m = cnt_m + v1_m - (fifo_wr_enable ? 1 : 0);
      v1_m  = mem_rd_en ? 1 : 0;
    end
    ncyc++;
  end

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; done_idx = -1; rd_total = 0; wr_total = 0;
    first_rd = -1; first_wr = -1; last_wr = -1;
  endtask

  // Returns the monitor index of the first cycle after the start edge.
  task automatic do_start(input int src, input int len, input bit expect_it, output int s);
    @(posedge wclk); #1;
    start = 1'b1; src_addr = src[AW-1:0]; length = len[AW:0];
    if (expect_it) begin
      for (int i = 0; i < len; i++) begin
        logic [AW-1:0] a;
        a = AW'(src + i);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(32'h100 + {{(DW-AW){1'b0}}, a});
      end
    end
    @(posedge wclk); #1;
    start = 1'b0;
    s = ncyc;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge wclk); #2;
      if (done_cnt > 0) seen = 1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout got no done within %0d cycles", name, budget);
    end
    repeat (3) @(posedge wclk);
    #1;
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge wclk); #1;
      if (wr_total >= n) seen = 1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_write_timeout got=%0d writes want=%0d", name, wr_total, n);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({mem_rd_en, mem_addr, fifo_wr_enable, fifo_wr_data, busy, done} !== '0) begin
      failures++;
      $display("FAIL %s got rd_en=%b addr=%0d wr_en=%b data=%h busy=%b done=%b want all 0",
               name, mem_rd_en, mem_addr, fifo_wr_enable, fifo_wr_data, busy, done);
    end
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; start = 1'b0; src_addr = '0; length = '0; fifo_full = 1'b0;
    #3;
    check_outputs_zero("reset_async");
    repeat (3) @(posedge wclk);
    #1;
    check_outputs_zero("reset_held");
    wrst_n = 1'b1;
    repeat (2) @(posedge wclk);
    #1;
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    int s;
    clear_stats();
    do_start(5, 4, 1, s);
    wait_done(40, "basic");
    check_int("basic_writes", wr_total, 4);
    check_int("basic_first_rd", first_rd - s, 0);
    check_int("basic_first_wr", first_wr - s, 2);
    check_int("basic_last_wr", last_wr - s, 5);
    check_int("basic_done_cnt", done_cnt, 1);
    check_int("basic_done_cycle", done_idx - s, 6);
    check_int("basic_busy_cycles", busy_cnt, 6);
    check_int("basic_queue_left", exp_data_q.size(), 0);
  endtask

  task automatic test_zero_length();
    int s;
    clear_stats();
    do_start(7, 0, 1, s);
    wait_done(10, "zero");
    check_int("zero_reads", rd_total, 0);
    check_int("zero_writes", wr_total, 0);
    check_int("zero_done_cnt", done_cnt, 1);
    check_int("zero_done_cycle", done_idx - s, 0);
    check_int("zero_busy_cycles", busy_cnt, 0);
  endtask

  task automatic test_wrap();
    int s;
    clear_stats();
    do_start(1022, 4, 1, s);
    wait_done(40, "wrap");
    check_int("wrap_writes", wr_total, 4);
    check_int("wrap_reads", rd_total, 4);
    check_int("wrap_queue_left", exp_data_q.size() + exp_addr_q.size(), 0);
  endtask

  task automatic test_backpressure();
    int s;
    clear_stats();
    do_start(20, 8, 1, s);
    wait_writes(2, 40, "bp");
    fifo_full = 1'b1;
    repeat (5) @(posedge wclk);
    #1;
    fifo_full = 1'b0;
    wait_done(60, "bp");
    check_int("bp_writes", wr_total, 8);
    check_int("bp_reads", rd_total, 8);
    check_int("bp_done_cnt", done_cnt, 1);
    check_int("bp_queue_left", exp_data_q.size(), 0);
  endtask

  task automatic test_reset_mid();
    int s;
    clear_stats();
    do_start(300, 8, 1, s);
    wait_writes(3, 40, "rst_mid");
    wrst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid_immediate");
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (3) @(posedge wclk);
    #1;
    check_outputs_zero("rst_mid_held");
    wrst_n = 1'b1;
    repeat (3) @(posedge wclk);
    check_int("rst_mid_no_done", done_cnt, 0);
    clear_stats();
    do_start(100, 2, 1, s);
    wait_done(30, "rst_mid_restart");
    check_int("rst_mid_restart_writes", wr_total, 2);
    check_int("rst_mid_restart_done", done_cnt, 1);
    check_int("rst_mid_queue_left", exp_data_q.size(), 0);
  endtask

  task automatic test_start_during_run();
    int s;
    clear_stats();
    do_start(40, 6, 1, s);
    @(posedge wclk); #1;
    start = 1'b1; src_addr = AW'(200); length = (AW+1)'(3);
    @(posedge wclk); #1;
    start = 1'b0;
    wait_done(40, "ignore_start");
    check_int("ignore_start_writes", wr_total, 6);
    check_int("ignore_start_done_cnt", done_cnt, 1);
    check_int("ignore_start_busy", busy_cnt, 8);
    check_int("ignore_start_queue_left", exp_data_q.size(), 0);
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_basic();
    test_zero_length();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_start_during_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_fifo_writer.md
DMA_FIFO_WRITER -- requirements
Module: dma_fifo_writer

Interface
REQ-001 The block SHALL have a parameter ADDR_W, default 10, giving the source memory address width.
REQ-002 The block SHALL have a parameter DATA_W, default 32, giving the data word width and matching the FIFO write port.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; both ports are listed below.
REQ-004 wclk  input  1  rising-edge clock shared with the FIFO write domain.
REQ-005 wrst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a transfer; it is sampled only in IDLE.
REQ-007 src_addr  input  ADDR_W  first source word address; it is captured on the start edge.
REQ-008 length  input  ADDR_W+1  number of words to transfer (0 to 2^ADDR_W); it is captured on the start edge.
REQ-009 mem_rd_en  output  1  source RAM read strobe.
REQ-010 mem_addr  output  ADDR_W  source RAM read address.
REQ-011 mem_rd_data  input  DATA_W  RAM read data; it is valid exactly one cycle after mem_rd_en.
REQ-012 fifo_full  input  1  FIFO write-side full flag.
REQ-013 fifo_wr_enable  output  1  FIFO write strobe.
REQ-014 fifo_wr_data  output  DATA_W  word presented to the FIFO.
REQ-015 busy  output  1  a transfer is in progress.
REQ-016 done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, RUN and DONE.
- IDLE -> RUN on start with length != 0.
- IDLE -> DONE on start with length == 0.
- RUN -> DONE on the edge where the last FIFO write is accepted.
- DONE -> IDLE unconditionally.
REQ-018 start SHALL be ignored while the FSM is in RUN or DONE.
REQ-019 busy SHALL be 1 exactly while the FSM is in RUN, and done SHALL be 1 exactly while the FSM is in DONE.
REQ-020 Each read SHALL use mem_addr equal to the current read pointer. The pointer SHALL be loaded from src_addr on start and incremented by 1 per read, wrapping modulo 2^ADDR_W.
REQ-021 The block SHALL contain a 2-entry buffer that captures mem_rd_data on the edge following each mem_rd_en.
REQ-022 mem_rd_en SHALL be asserted only when all of the following hold:
- the FSM is in RUN;
- reads issued < length;
- (buffer count + reads in flight - write accepted this cycle) < 2.
REQ-023 fifo_wr_enable SHALL equal (buffer not empty AND NOT fifo_full), combinationally.
REQ-024 fifo_wr_data SHALL equal the buffer head word, and the head SHALL be popped on every edge where fifo_wr_enable is 1.
REQ-025 Latency: with fifo_full low, the first mem_rd_en SHALL occur in the cycle after start is sampled, and the first fifo_wr_enable SHALL occur 2 cycles after start is sampled.
REQ-026 Throughput: with fifo_full held low, the block SHALL sustain one FIFO write per cycle, and a transfer of N words SHALL complete with done high N+2 cycles after the start edge.
REQ-027 When fifo_full rises mid-burst, the block SHALL lose no words and duplicate no words. The buffer absorbs the in-flight read, reads stall, and writing resumes with the head word in the first cycle fifo_full is low.
REQ-028 The block SHALL produce exactly length FIFO writes per transfer, in ascending address order.
REQ-029 The counters of reads issued and words written SHALL be ADDR_W+1 bits wide, so that length = 2^ADDR_W is supported.

Reset
REQ-030 While wrst_n is low, the following SHALL all be 0 independent of wclk: mem_rd_en, mem_addr, fifo_wr_enable, fifo_wr_data, busy and done. The FSM SHALL be in IDLE and the buffer SHALL be empty.
REQ-031 When reset is asserted mid-transfer, the block SHALL abort the transfer, discard any in-flight read data and buffered words, and not pulse done. After release, the block SHALL accept a new start.

Verification
REQ-032 RAM[i]=i+0x100; src_addr=5, length=4, fifo_full=0 -> FIFO receives 0x105, 0x106, 0x107, 0x108 on 4 consecutive cycles; done pulses once; busy is high for 6 cycles.
REQ-033 length=0 -> no mem_rd_en and no fifo_wr_enable; done pulses in the cycle after start; busy stays 0.
REQ-034 src_addr=1022, length=4 (ADDR_W=10) -> reads at 1022, 1023, 0, 1; the data arrives in that order.
REQ-035 length=8 with fifo_full forced high for 5 cycles after the 2nd write -> all 8 words are delivered once each, in order; mem_rd_en is never asserted with 2 words buffered.
REQ-036 wrst_n pulsed low after 3 of 8 writes -> all outputs are 0 immediately and no done pulse occurs; a new start with length=2 then delivers exactly 2 words.
REQ-037 start asserted during RUN with different src_addr/length -> it is ignored; the original transfer completes unchanged.
